serial_tx_shifter: RTL and testbench



---
 rtl/serial_tx_shifter.sv | 159 +++++++++++++++
 tb/tb_serial_tx_shifter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial front end: double-buffered WIDTH-bit words out MSB first on dout.
// Optional build macro SERIAL_PARITY_EN appends one even-parity bit after each word.
module serial_tx_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
`ifdef SERIAL_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;
    logic             last_bit;
    logic             can_load;
    logic             load_en;
    logic [WIDTH-1:0] load_word;

    // Ready looks only at registered state so upstream can never form a loop through it.
    assign word_ready = !hold_full_q;
    assign busy       = (state_q != S_IDLE) || hold_full_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

    always_comb begin
        accept   = word_valid && word_ready;
        last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(1));
`ifdef SERIAL_PARITY_EN
        can_load = (state_q == S_IDLE) || (state_q == S_PARITY);
`else
        can_load = (state_q == S_IDLE) || last_bit;
`endif
    end

    // Buffer management: the holding register always feeds the shifter before a fresh word.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load_en     = 1'b0;
        load_word   = '0;
        if (can_load) begin
            if (hold_full_q) begin
                load_en   = 1'b1;
                load_word = hold_q;
                if (accept) begin
                    hold_d      = word_in;
                    hold_full_d = 1'b1;
                end else begin
                    hold_full_d = 1'b0;
                end
            end else if (accept) begin
                load_en   = 1'b1;
                load_word = word_in;
            end
        end else if (accept) begin
            hold_d      = word_in;
            hold_full_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
`ifdef SERIAL_PARITY_EN
        parity_d     = parity_q;
`endif
        if (load_en) begin
            // The MSB goes straight to dout; sh keeps the remaining bits left-aligned.
            state_d      = S_SHIFT;
            sh_d         = {load_word[WIDTH-2:0], 1'b0};
            cnt_d        = CW'(WIDTH);
            dout_d       = load_word[WIDTH-1];
            dout_valid_d = 1'b1;
`ifdef SERIAL_PARITY_EN
            parity_d     = ^load_word;
`endif
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (last_bit) begin
                        cnt_d = '0;
`ifdef SERIAL_PARITY_EN
                        state_d      = S_PARITY;
                        dout_d       = parity_q;
                        dout_valid_d = 1'b1;
`else
                        state_d      = S_IDLE;
`endif
                    end else begin
                        dout_d       = sh_q[WIDTH-1];
                        dout_valid_d = 1'b1;
                        sh_d         = {sh_q[WIDTH-2:0], 1'b0};
                        cnt_d        = cnt_q - CW'(1);
                    end
                end
`ifdef SERIAL_PARITY_EN
                S_PARITY: begin
                    state_d = S_IDLE;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sh_q         <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
`ifdef SERIAL_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed bench for serial_tx_shifter: an 8-bit instance and a 5-bit instance.
// Parity-specific steps are built only when SERIAL_PARITY_EN is defined.
module tb_serial_tx_shifter;

    logic       clk;
    logic       reset;
    logic [7:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic       dout;
    logic       dout_valid;
    logic       busy;

    logic [4:0] word_in5;
    logic       word_valid5;
    logic       word_ready5;
    logic       dout5;
    logic       dout_valid5;
    logic       busy5;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_tx_shifter #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    serial_tx_shifter #(.WIDTH(5)) u_dut5 (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in5),
        .word_valid (word_valid5),
        .word_ready (word_ready5),
        .dout       (dout5),
        .dout_valid (dout_valid5),
        .busy       (busy5)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] p16;
        logic [23:0] p24;
        logic [4:0]  p5;

        clk         = 1'b0;
        reset       = 1'b1;
        word_in     = '0;
        word_valid  = 1'b0;
        word_in5    = '0;
        word_valid5 = 1'b0;
        tick; tick; tick;
        reset = 1'b0;
        chk("rst_dout", dout, 1'b0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_ready", word_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // Single word 0xD8: bits 1,1,0,1,1,0,0,0 in cycles 1..8.
        w          = 8'hD8;
        word_in    = w;
        word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("single_bit%0d", i), dout, w[8-i]);
            chk($sformatf("single_vld%0d", i), dout_valid, 1'b1);
            tick;
        end
`ifdef SERIAL_PARITY_EN
        chk("single_par", dout, 1'b0);
        chk("single_par_vld", dout_valid, 1'b1);
        tick;
`endif
        chk("single_idle_dout", dout, 1'b0);
        chk("single_idle_vld", dout_valid, 1'b0);
        chk("single_idle_busy", busy, 1'b0);

`ifdef SERIAL_PARITY_EN
        // 0xD9 has five ones, so the parity bit is 1.
        w          = 8'hD9;
        word_in    = w;
        word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("par_bit%0d", i), dout, w[8-i]);
            tick;
        end
        chk("par_d9", dout, 1'b1);
        chk("par_d9_vld", dout_valid, 1'b1);
        tick;
        chk("par_d9_idle", dout_valid, 1'b0);
`else
        // Back-to-back 0xDB, 0x1B: 16 contiguous valid bits.
        p16        = 16'hDB1B;
        word_in    = 8'hDB;
        word_valid = 1'b1;
        tick;
        for (int i = 1; i <= 16; i++) begin
            if (i == 1) begin
                word_in = 8'h1B;
                chk("b2b_ready1", word_ready, 1'b1);
            end
            if (i == 2) begin
                word_valid = 1'b0;
                chk("b2b_ready2", word_ready, 1'b0);
            end
            if (i == 8) chk("b2b_ready8", word_ready, 1'b0);
            if (i == 9) chk("b2b_ready9", word_ready, 1'b1);
            chk($sformatf("b2b_bit%0d", i), dout, p16[16-i]);
            chk($sformatf("b2b_vld%0d", i), dout_valid, 1'b1);
            tick;
        end
        chk("b2b_idle_vld", dout_valid, 1'b0);
        chk("b2b_idle_busy", busy, 1'b0);

        // Backpressure: A5, 3C, 96 with valid held high; accepts at edges 0, 1, 9.
        p24        = 24'hA53C96;
        word_in    = 8'hA5;
        word_valid = 1'b1;
        tick;
        for (int i = 1; i <= 24; i++) begin
            if (i == 1) word_in = 8'h3C;
            else if (i >= 2 && i <= 8) word_in = 8'($urandom);
            else if (i == 9) word_in = 8'h96;
            else if (i == 10) word_valid = 1'b0;
            chk($sformatf("bp_ready%0d", i), word_ready,
                (i == 1 || i == 9 || i >= 17) ? 1'b1 : 1'b0);
            chk($sformatf("bp_bit%0d", i), dout, p24[24-i]);
            chk($sformatf("bp_vld%0d", i), dout_valid, 1'b1);
            tick;
        end
        chk("bp_idle_vld", dout_valid, 1'b0);
        chk("bp_idle_busy", busy, 1'b0);
`endif

        // Reset in cycle 4 of 0xFF with 0x42 held.
        word_in    = 8'hFF;
        word_valid = 1'b1;
        tick;
        word_in = 8'h42;
        tick;
        word_valid = 1'b0;
        chk("rm_busy2", busy, 1'b1);
        chk("rm_ready2", word_ready, 1'b0);
        tick;
        tick;
        chk("rm_dout4", dout, 1'b1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rm_dout5", dout, 1'b0);
        chk("rm_vld5", dout_valid, 1'b0);
        chk("rm_ready5", word_ready, 1'b1);
        chk("rm_busy5", busy, 1'b0);
        w          = 8'h81;
        word_in    = w;
        word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("rm_bit%0d", i), dout, w[8-i]);
            chk($sformatf("rm_vld%0d", i), dout_valid, 1'b1);
            tick;
        end
`ifdef SERIAL_PARITY_EN
        chk("rm_par", dout, 1'b0);
        tick;
`endif
        chk("rm_idle_vld", dout_valid, 1'b0);
        chk("rm_idle_busy", busy, 1'b0);

`ifndef SERIAL_PARITY_EN
        // WIDTH=5, 11011 three times: accepts at edges 0, 1, 6; 15 contiguous bits.
        p5          = 5'b11011;
        word_in5    = p5;
        word_valid5 = 1'b1;
        tick;
        for (int i = 1; i <= 15; i++) begin
            if (i == 2) chk("w5_ready2", word_ready5, 1'b0);
            if (i == 5) chk("w5_ready5", word_ready5, 1'b0);
            if (i == 6) chk("w5_ready6", word_ready5, 1'b1);
            if (i == 7) word_valid5 = 1'b0;
            chk($sformatf("w5_bit%0d", i), dout5, p5[4 - ((i - 1) % 5)]);
            chk($sformatf("w5_vld%0d", i), dout_valid5, 1'b1);
            tick;
        end
        chk("w5_idle_vld", dout_valid5, 1'b0);
        chk("w5_idle_busy", busy5, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
